alu_reservation_station: RTL
============================

# alu_reservation_station

Three-entry reservation station that buffers issued ALU instructions, captures pending operands by snooping the common data bus (CDB), and dispatches ready instructions to the ALU execution unit. It sits between the issue/rename stage and the ALU/state-controller pair. It presents one ready instruction per cycle with `outEn`. The ALU side consumes it when its `EXEable` (available) input is high in the same cycle.

## Interface
- `ENTRIES`, 3: number of station slots (1..7).
- `LABEL_BASE`, 4'd1: label of slot 0; slot i has label `LABEL_BASE+i`. Label 0 is reserved and means "value valid, no producer".
- `clk`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `issueEN`  in  1  issue request this cycle.
- `issueOp`  in  3  ALU opcode (ALUAdd/Sub/And/Or/Xor/Nor/Slt encodings).
- `issueData1`, `issueData2`  in  32  operand values, meaningful when the matching label is 0.
- `issueLabel1`, `issueLabel2`  in  4  producer label per operand; 0 = value present.
- `issueFull`  out  1  no free slot.
- `issueLabelOut`  out  4  label that an issue this cycle will receive; 0 when full.
- `cdbEN`  in  1  CDB broadcast valid.
- `cdbLabel`  in  4  broadcasting producer label.
- `cdbData`  in  32  broadcast value.
- `EXEable`  in  1  ALU can accept this cycle.
- `outEn`  out  1  a ready instruction is presented.
- `opOut`  out  3  opcode of the presented instruction.
- `dataOut1`, `dataOut2`  out  32  operands of the presented instruction.
- `readyLabelOut`  out  4  label of the presented slot.

## Operation
- Each slot holds these registered fields: busy, op, V1/Q1, V2/Q2. A slot is ready when busy, Q1==0 and Q2==0. Readiness is computed from registered state only.
- Free-slot select: the lowest-index non-busy slot. `issueLabelOut` = `LABEL_BASE` + that index. `issueFull` = all slots busy.
- Issue (`issueEN` && !`issueFull`):
  - Write the op into the selected slot and set busy.
  - For each operand: if the label is 0, store the data with Q=0.
  - Otherwise, if `cdbEN` && `cdbLabel`==label, store `cdbData` with Q=0 (same-cycle bypass).
  - Otherwise store Q=label and V=0.
- Issue while full: ignored, no state change.
- CDB snoop: when `cdbEN` && `cdbLabel`!=0, every busy slot with Q1 (or Q2) == `cdbLabel` latches `cdbData` into V and clears Q. Both operands of one slot may capture the same broadcast. `cdbEN` with label 0 has no effect.
- Dispatch select: the lowest-index ready slot. `outEn`=1, and `opOut`/`dataOut*`/`readyLabelOut` come from that slot.
  - With no ready slot: `outEn`=0 and all other dispatch outputs are 0.
  - Selection is by index, not age.
- Dispatch handshake: at a rising edge with `outEn` && `EXEable`, the presented slot's busy is cleared. When `EXEable`=0, outputs stay stable until accepted, unless a lower-index slot becomes ready and takes the presentation.
- Reset (`RST`=1 at an edge): all busy, Q and V fields cleared. This gives `outEn`=0, `opOut`=0, `dataOut*`=0, `readyLabelOut`=0, `issueFull`=0 and `issueLabelOut`=`LABEL_BASE`. Reset overrides any simultaneous issue, snoop or dispatch.

## Timing
- All outputs are combinational from registered slot state. No input-to-output combinational path exists, except `issueFull` and `issueLabelOut`, which depend on state only.
- Issue with both operands valid at edge N: `outEn`=1 during cycle N+1, dispatch at edge N+1 if `EXEable`. Minimum issue-to-dispatch is 1 cycle.
- Operand arriving on the CDB at edge N (snoop or bypass): the slot becomes ready in cycle N+1.
- A slot freed by dispatch at edge N is free from cycle N+1. There is no same-cycle reuse.
- Issue, snoop and dispatch to different slots may all occur at the same edge.
- A snoop targeting the slot being dispatched at the same edge is irrelevant, because a dispatched slot has Q==0.

## Test plan
- Reset, then issue op=ALUAdd, D1=5, D2=7, labels 0 -> `issueLabelOut`=1; next cycle `outEn`=1, `dataOut1`=5, `dataOut2`=7, `readyLabelOut`=1. With `EXEable`=1, `outEn`=0 the following cycle.
- Issue ALUSub with Label1=4, D2=3 -> `outEn` stays 0. Then `cdbEN`=1, `cdbLabel`=4, `cdbData`=10 -> next cycle `outEn`=1, `dataOut1`=10, `dataOut2`=3.
- Same-cycle bypass: issue with Label2=6 while `cdbEN`=1, `cdbLabel`=6, `cdbData`=0xFFFFFFFF -> next cycle `dataOut2`=0xFFFFFFFF, `outEn`=1.
- Fill: three issues with `EXEable`=0 -> `issueFull`=1 and `issueLabelOut`=0. A fourth issue is ignored. With `EXEable`=1, slots 1, 2, 3 dispatch in index order on consecutive cycles.
- Dispatch slot 1 and issue in the same cycle while full -> the issue is ignored. The next cycle `issueFull`=0, `issueLabelOut`=1.
- Assert `RST` with 2 busy slots and a CDB broadcast pending -> next cycle `outEn`=0, `issueFull`=0, `issueLabelOut`=1, and all dispatch outputs are 0.

Source files
------------

// File: rtl/alu_reservation_station_if.sv
// rtl/alu_reservation_station_if.sv - issue, CDB and dispatch bundle of the ALU reservation station
// The master drives issue/CDB/EXEable and observes station status; the station is the slave.
interface alu_reservation_station_if;
    logic        issueEN;
    logic [2:0]  issueOp;
    logic [31:0] issueData1;
    logic [31:0] issueData2;
    logic [3:0]  issueLabel1;
    logic [3:0]  issueLabel2;
    logic        issueFull;
    logic [3:0]  issueLabelOut;

    logic        cdbEN;
    logic [3:0]  cdbLabel;
    logic [31:0] cdbData;

    logic        EXEable;
    logic        outEn;
    logic [2:0]  opOut;
    logic [31:0] dataOut1;
    logic [31:0] dataOut2;
    logic [3:0]  readyLabelOut;

    modport master (
        output issueEN, issueOp, issueData1, issueData2, issueLabel1, issueLabel2,
        output cdbEN, cdbLabel, cdbData,
        output EXEable,
        input  issueFull, issueLabelOut,
        input  outEn, opOut, dataOut1, dataOut2, readyLabelOut
    );

    modport slave (
        input  issueEN, issueOp, issueData1, issueData2, issueLabel1, issueLabel2,
        input  cdbEN, cdbLabel, cdbData,
        input  EXEable,
        output issueFull, issueLabelOut,
        output outEn, opOut, dataOut1, dataOut2, readyLabelOut
    );
endinterface

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - reservation station buffering ALU ops until operands arrive
// Slots capture missing operands from the CDB and dispatch the lowest-index ready slot.
module alu_reservation_station #(
    parameter int         ENTRIES    = 3,
    parameter logic [3:0] LABEL_BASE = 4'd1
) (
    input  logic clk,
    input  logic RST,
    alu_reservation_station_if.slave bus
);

    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] busy;
    logic [2:0]         op_q [ENTRIES];
    logic [31:0]        v1_q [ENTRIES];
    logic [31:0]        v2_q [ENTRIES];
    logic [3:0]         q1_q [ENTRIES];
    logic [3:0]         q2_q [ENTRIES];

    logic [ENTRIES-1:0] slot_ready;
    logic               free_found;
    logic [IW-1:0]      free_idx;
    logic               disp_found;
    logic [IW-1:0]      disp_idx;
    logic [2:0]         op_sel;
    logic [31:0]        d1_sel;
    logic [31:0]        d2_sel;

    logic               issue_fire;
    logic               dispatch_fire;
    logic               cdb_hit;
    logic [31:0]        new_v1;
    logic [31:0]        new_v2;
    logic [3:0]         new_q1;
    logic [3:0]         new_q2;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            slot_ready[i] = busy[i] && (q1_q[i] == 4'd0) && (q2_q[i] == 4'd0);
        end
    end

    // Descending scan so the lowest index wins both selections.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        op_sel     = 3'd0;
        d1_sel     = 32'd0;
        d2_sel     = 32'd0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (slot_ready[i]) begin
                disp_found = 1'b1;
                disp_idx   = IW'(i);
                op_sel     = op_q[i];
                d1_sel     = v1_q[i];
                d2_sel     = v2_q[i];
            end
        end
    end

    assign bus.issueFull     = !free_found;
    assign bus.issueLabelOut = free_found ? (LABEL_BASE + 4'(free_idx)) : 4'd0;
    assign bus.outEn         = disp_found;
    assign bus.opOut         = op_sel;
    assign bus.dataOut1      = d1_sel;
    assign bus.dataOut2      = d2_sel;
    assign bus.readyLabelOut = disp_found ? (LABEL_BASE + 4'(disp_idx)) : 4'd0;

    assign issue_fire    = bus.issueEN && free_found;
    assign dispatch_fire = disp_found && bus.EXEable;
    assign cdb_hit       = bus.cdbEN && (bus.cdbLabel != 4'd0);

    // An operand broadcast in the issue cycle itself is taken straight off the CDB.
    always_comb begin
        new_v1 = 32'd0;
        new_q1 = 4'd0;
        if (bus.issueLabel1 == 4'd0) begin
            new_v1 = bus.issueData1;
        end else if (bus.cdbEN && (bus.cdbLabel == bus.issueLabel1)) begin
            new_v1 = bus.cdbData;
        end else begin
            new_q1 = bus.issueLabel1;
        end
    end

    always_comb begin
        new_v2 = 32'd0;
        new_q2 = 4'd0;
        if (bus.issueLabel2 == 4'd0) begin
            new_v2 = bus.issueData2;
        end else if (bus.cdbEN && (bus.cdbLabel == bus.issueLabel2)) begin
            new_v2 = bus.cdbData;
        end else begin
            new_q2 = bus.issueLabel2;
        end
    end

    // Issue targets a free slot, dispatch and snoop only busy ones, so they never collide.
    always_ff @(posedge clk) begin
        if (RST) begin
            busy <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                op_q[i] <= 3'd0;
                v1_q[i] <= 32'd0;
                v2_q[i] <= 32'd0;
                q1_q[i] <= 4'd0;
                q2_q[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (dispatch_fire && (disp_idx == IW'(i))) begin
                    busy[i] <= 1'b0;
                end
                if (busy[i] && cdb_hit && (q1_q[i] == bus.cdbLabel)) begin
                    v1_q[i] <= bus.cdbData;
                    q1_q[i] <= 4'd0;
                end
                if (busy[i] && cdb_hit && (q2_q[i] == bus.cdbLabel)) begin
                    v2_q[i] <= bus.cdbData;
                    q2_q[i] <= 4'd0;
                end
                if (issue_fire && (free_idx == IW'(i))) begin
                    busy[i] <= 1'b1;
                    op_q[i] <= bus.issueOp;
                    v1_q[i] <= new_v1;
                    v2_q[i] <= new_v2;
                    q1_q[i] <= new_q1;
                    q2_q[i] <= new_q2;
                end
            end
        end
    end

endmodule
